// File: rtl/riscv_victim_fill_ctrl.sv
// Victim-cache fill controller: services L1 misses from a 2-way victim cache,
// swapping the displaced L1 line in on a hit or fetching from memory on a miss.
//
// state   | meaning
// IDLE    | ready for an L1 miss request
// LOOKUP  | probe victim cache with the missing tag/idx
// SWAP    | victim hit: overwrite hit way with the evicted line (or invalidate)
// MEMREQ  | present line fetch address until memory accepts
// MEMWAIT | wait for memory line data
// INSERT  | victim miss: place evicted line into the replacement way
// RESP    | hold refill data to L1 until accepted
module riscv_victim_fill_ctrl #(
  parameter int TAG_BITS = 25,
  parameter int IDX_BITS = 3,
  parameter int OFF_BITS = 4,
  parameter int BLK_SIZE = 128
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                miss_val,
  output logic                miss_rdy,
  input  logic [TAG_BITS-1:0] miss_tag,
  input  logic [IDX_BITS-1:0] miss_idx,
  input  logic                evict_val,
  input  logic [TAG_BITS-1:0] evict_tag,
  input  logic [IDX_BITS-1:0] evict_idx,
  input  logic [BLK_SIZE-1:0] evict_data,
  output logic                vc_lookup_en,
  output logic [TAG_BITS-1:0] vc_lookup_tag,
  output logic [IDX_BITS-1:0] vc_lookup_idx,
  input  logic                vc_lookup_hit,
  input  logic                vc_lookup_way,
  input  logic [BLK_SIZE-1:0] vc_lookup_data,
  input  logic                vc_repl_way,
  output logic                vc_write_en,
  output logic                vc_write_way,
  output logic [TAG_BITS-1:0] vc_write_tag,
  output logic [IDX_BITS-1:0] vc_write_idx,
  output logic [BLK_SIZE-1:0] vc_write_data,
  output logic                vc_write_valid,
  output logic                mem_req_val,
  input  logic                mem_req_rdy,
  output logic [31:0]         mem_req_addr,
  input  logic                mem_resp_val,
  input  logic [BLK_SIZE-1:0] mem_resp_data,
  output logic                refill_val,
  input  logic                refill_rdy,
  output logic [BLK_SIZE-1:0] refill_data,
  output logic                refill_src,
  output logic [15:0]         stat_hits,
  output logic [15:0]         stat_misses
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_SWAP, S_MEMREQ, S_MEMWAIT, S_INSERT, S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [TAG_BITS-1:0] tag_q;
  logic [IDX_BITS-1:0] idx_q;
  logic                ev_val_q;
  logic [TAG_BITS-1:0] ev_tag_q;
  logic [IDX_BITS-1:0] ev_idx_q;
  logic [BLK_SIZE-1:0] ev_data_q;
  logic                hit_way_q;
  logic [BLK_SIZE-1:0] line_q;
  logic                src_q;
  logic [15:0]         stat_hits_q;
  logic [15:0]         stat_misses_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      tag_q         <= '0;
      idx_q         <= '0;
      ev_val_q      <= 1'b0;
      ev_tag_q      <= '0;
      ev_idx_q      <= '0;
      ev_data_q     <= '0;
      hit_way_q     <= 1'b0;
      line_q        <= '0;
      src_q         <= 1'b0;
      stat_hits_q   <= '0;
      stat_misses_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (miss_val) begin
            tag_q     <= miss_tag;
            idx_q     <= miss_idx;
            ev_val_q  <= evict_val;
            ev_tag_q  <= evict_tag;
            ev_idx_q  <= evict_idx;
            ev_data_q <= evict_data;
          end
        end
        S_LOOKUP: begin
          // refill source is decided here so it stays fixed through RESP
          src_q <= vc_lookup_hit;
          if (vc_lookup_hit) begin
            line_q      <= vc_lookup_data;
            hit_way_q   <= vc_lookup_way;
            stat_hits_q <= stat_hits_q + 16'd1;
          end else begin
            stat_misses_q <= stat_misses_q + 16'd1;
          end
        end
        S_MEMWAIT: begin
          if (mem_resp_val) line_q <= mem_resp_data;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d        = state_q;
    miss_rdy       = 1'b0;
    vc_lookup_en   = 1'b0;
    vc_write_en    = 1'b0;
    vc_write_way   = 1'b0;
    vc_write_valid = 1'b0;
    mem_req_val    = 1'b0;
    refill_val     = 1'b0;
    case (state_q)
      S_IDLE: begin
        miss_rdy = 1'b1;
        if (miss_val) state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        vc_lookup_en = 1'b1;
        state_d      = vc_lookup_hit ? S_SWAP : S_MEMREQ;
      end
      S_SWAP: begin
        // without a displaced line the hit entry is simply invalidated
        vc_write_en    = 1'b1;
        vc_write_way   = hit_way_q;
        vc_write_valid = ev_val_q;
        state_d        = S_RESP;
      end
      S_MEMREQ: begin
        mem_req_val = 1'b1;
        if (mem_req_rdy) state_d = S_MEMWAIT;
      end
      S_MEMWAIT: begin
        if (mem_resp_val) state_d = S_INSERT;
      end
      S_INSERT: begin
        vc_write_en    = ev_val_q;
        vc_write_way   = vc_repl_way;
        vc_write_valid = 1'b1;
        state_d        = S_RESP;
      end
      S_RESP: begin
        refill_val = 1'b1;
        if (refill_rdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign vc_lookup_tag = tag_q;
  assign vc_lookup_idx = idx_q;
  assign vc_write_tag  = ev_tag_q;
  assign vc_write_idx  = ev_idx_q;
  assign vc_write_data = ev_data_q;
  assign mem_req_addr  = {tag_q, idx_q, {OFF_BITS{1'b0}}};
  assign refill_data   = line_q;
  assign refill_src    = src_q;
  assign stat_hits     = stat_hits_q;
  assign stat_misses   = stat_misses_q;

endmodule

// File: tb/tb_riscv_victim_fill_ctrl.sv
// Directed bench for riscv_victim_fill_ctrl with a two-entry victim-cache model,
// a vector table of miss transactions and hand sequences for reset and wrap.
module tb_riscv_victim_fill_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         miss_val, miss_rdy;
  logic [24:0]  miss_tag;
  logic [2:0]   miss_idx;
  logic         evict_val;
  logic [24:0]  evict_tag;
  logic [2:0]   evict_idx;
  logic [127:0] evict_data;
  logic         vc_lookup_en;
  logic [24:0]  vc_lookup_tag;
  logic [2:0]   vc_lookup_idx;
  logic         vc_lookup_hit, vc_lookup_way;
  logic [127:0] vc_lookup_data;
  logic         vc_repl_way;
  logic         vc_write_en, vc_write_way, vc_write_valid;
  logic [24:0]  vc_write_tag;
  logic [2:0]   vc_write_idx;
  logic [127:0] vc_write_data;
  logic         mem_req_val, mem_req_rdy;
  logic [31:0]  mem_req_addr;
  logic         mem_resp_val;
  logic [127:0] mem_resp_data;
  logic         refill_val, refill_rdy, refill_src;
  logic [127:0] refill_data;
  logic [15:0]  stat_hits, stat_misses;

  int n_chk = 0;
  int n_fail = 0;

  localparam logic [127:0] DA = {4{32'hDA7A_0001}};
  localparam logic [127:0] E0 = {4{32'hE0E0_0000}};
  localparam logic [127:0] E1 = {4{32'hE1E1_1111}};
  localparam logic [127:0] E3 = {4{32'hE3E3_3333}};
  localparam logic [127:0] E5 = {4{32'hE5E5_5555}};
  localparam logic [127:0] D0 = {4{32'hD0D0_0A0A}};
  localparam logic [127:0] D3 = {4{32'hD3D3_3B3B}};
  localparam logic [127:0] D4 = {4{32'hD4D4_4C4C}};
  localparam logic [127:0] D6 = {4{32'hD6D6_6E6E}};

  riscv_victim_fill_ctrl dut (
    .clk(clk), .reset(reset),
    .miss_val(miss_val), .miss_rdy(miss_rdy), .miss_tag(miss_tag), .miss_idx(miss_idx),
    .evict_val(evict_val), .evict_tag(evict_tag), .evict_idx(evict_idx), .evict_data(evict_data),
    .vc_lookup_en(vc_lookup_en), .vc_lookup_tag(vc_lookup_tag), .vc_lookup_idx(vc_lookup_idx),
    .vc_lookup_hit(vc_lookup_hit), .vc_lookup_way(vc_lookup_way), .vc_lookup_data(vc_lookup_data),
    .vc_repl_way(vc_repl_way),
    .vc_write_en(vc_write_en), .vc_write_way(vc_write_way), .vc_write_tag(vc_write_tag),
    .vc_write_idx(vc_write_idx), .vc_write_data(vc_write_data), .vc_write_valid(vc_write_valid),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_addr(mem_req_addr),
    .mem_resp_val(mem_resp_val), .mem_resp_data(mem_resp_data),
    .refill_val(refill_val), .refill_rdy(refill_rdy), .refill_data(refill_data),
    .refill_src(refill_src), .stat_hits(stat_hits), .stat_misses(stat_misses)
  );

  always #5 clk = ~clk;

  // two-entry victim cache; entry 1 starts out holding tag 0x10 / idx 2
  logic         m_v    [2] = '{1'b0, 1'b1};
  logic [24:0]  m_tag  [2] = '{25'h0, 25'h10};
  logic [2:0]   m_idx  [2] = '{3'd0, 3'd2};
  logic [127:0] m_data [2] = '{128'h0, DA};
  logic hit0, hit1;

  assign hit0 = m_v[0] && m_tag[0] == vc_lookup_tag && m_idx[0] == vc_lookup_idx;
  assign hit1 = m_v[1] && m_tag[1] == vc_lookup_tag && m_idx[1] == vc_lookup_idx;
  assign vc_lookup_hit  = hit0 | hit1;
  assign vc_lookup_way  = !hit0;
  assign vc_lookup_data = hit0 ? m_data[0] : m_data[1];

  always @(posedge clk) begin
    if (vc_write_en) begin
      m_v[vc_write_way]    <= vc_write_valid;
      m_tag[vc_write_way]  <= vc_write_tag;
      m_idx[vc_write_way]  <= vc_write_idx;
      m_data[vc_write_way] <= vc_write_data;
    end
  end

  typedef struct {
    logic [24:0]  tag;
    logic [2:0]   idx;
    logic         ev_val;
    logic [24:0]  ev_tag;
    logic [2:0]   ev_idx;
    logic [127:0] ev_data;
    logic         repl_way;
    int           req_stall;
    int           refill_stall;
    logic [127:0] mem_data;
    logic         exp_src;
    logic [127:0] exp_refill;
    logic [31:0]  exp_addr;
    logic         exp_wr;
    logic         exp_wr_way;
    logic         exp_wr_valid;
    logic [15:0]  exp_hits;
    logic [15:0]  exp_misses;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [24:0] tag, input logic [2:0] idx, input logic ev_val, input logic [24:0] ev_tag,
    input logic [2:0] ev_idx, input logic [127:0] ev_data, input logic repl_way, input int rs,
    input int fs, input logic [127:0] mem_data, input logic src, input logic [127:0] refill,
    input logic [31:0] addr, input logic wr, input logic wr_way, input logic wr_valid,
    input logic [15:0] hits, input logic [15:0] misses);
    vec_t v;
    v.tag = tag; v.idx = idx; v.ev_val = ev_val; v.ev_tag = ev_tag; v.ev_idx = ev_idx;
    v.ev_data = ev_data; v.repl_way = repl_way; v.req_stall = rs; v.refill_stall = fs;
    v.mem_data = mem_data; v.exp_src = src; v.exp_refill = refill; v.exp_addr = addr;
    v.exp_wr = wr; v.exp_wr_way = wr_way; v.exp_wr_valid = wr_valid;
    v.exp_hits = hits; v.exp_misses = misses;
    return v;
  endfunction

  task automatic run_vec(input int id, input vec_t v);
    int cyc = 0, nreq = 0, nref = 0, nwr = 0, nlook = 0, mw = 0, lat = 0;
    bit done = 0, resp_sent = 0, addr_bad = 0, data_bad = 0, rdy_bad = 0, both_bad = 0;
    logic [31:0]  addr0 = '0;
    logic [127:0] ref0 = '0;
    logic         src0 = 1'b0;
    logic         w_way = 1'b0, w_valid = 1'b0;
    logic [24:0]  w_tag = '0, l_tag = '0;
    logic [2:0]   w_idx = '0, l_idx = '0;
    logic [127:0] w_data = '0;
    string p = $sformatf("v%0d", id);
    @(negedge clk);
    chk({p, "_miss_rdy_idle"}, miss_rdy, 1'b1);
    miss_val = 1'b1; miss_tag = v.tag; miss_idx = v.idx;
    evict_val = v.ev_val; evict_tag = v.ev_tag; evict_idx = v.ev_idx; evict_data = v.ev_data;
    vc_repl_way = v.repl_way; mem_req_rdy = 1'b0; refill_rdy = 1'b0; mem_resp_val = 1'b0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      miss_val = 1'b0;
      if (vc_lookup_en && vc_write_en) both_bad = 1;
      if (miss_rdy && (vc_lookup_en || vc_write_en || mem_req_val || refill_val)) rdy_bad = 1;
      if (vc_lookup_en) begin nlook++; l_tag = vc_lookup_tag; l_idx = vc_lookup_idx; end
      if (vc_write_en) begin
        nwr++; w_way = vc_write_way; w_valid = vc_write_valid;
        w_tag = vc_write_tag; w_idx = vc_write_idx; w_data = vc_write_data;
      end
      if (mem_req_val) begin
        nreq++;
        if (nreq == 1) addr0 = mem_req_addr;
        else if (mem_req_addr !== addr0) addr_bad = 1;
        mem_req_rdy = (nreq > v.req_stall);
      end else mem_req_rdy = 1'b0;
      if (nreq > 0 && !mem_req_val && !resp_sent) begin
        mw++;
        if (mw == 2) begin mem_resp_val = 1'b1; mem_resp_data = v.mem_data; resp_sent = 1; end
      end else mem_resp_val = 1'b0;
      if (refill_val) begin
        nref++;
        if (nref == 1) begin lat = cyc; ref0 = refill_data; src0 = refill_src; end
        else if (refill_data !== ref0 || refill_src !== src0) data_bad = 1;
        refill_rdy = (nref > v.refill_stall);
      end else if (nref > 0) begin
        done = 1; refill_rdy = 1'b0;
      end
    end
    chk({p, "_completed"}, done, 1'b1);
    chk({p, "_lookups"}, nlook, 1);
    chk({p, "_lookup_key"}, {l_tag, l_idx}, {v.tag, v.idx});
    chk({p, "_lookup_write_overlap"}, both_bad, 1'b0);
    chk({p, "_miss_rdy_busy"}, rdy_bad, 1'b0);
    chk({p, "_refill_src"}, src0, v.exp_src);
    chk({p, "_refill_data"}, ref0, v.exp_refill);
    chk({p, "_refill_stable"}, data_bad, 1'b0);
    chk({p, "_refill_cycles"}, nref, v.refill_stall + 1);
    chk({p, "_writes"}, nwr, v.exp_wr ? 1 : 0);
    if (v.exp_wr) begin
      chk({p, "_wr_way"}, w_way, v.exp_wr_way);
      chk({p, "_wr_valid"}, w_valid, v.exp_wr_valid);
      chk({p, "_wr_line"}, {w_tag, w_idx, w_data}, {v.ev_tag, v.ev_idx, v.ev_data});
    end
    if (v.exp_src) begin
      chk({p, "_hit_latency"}, lat, 3);
      chk({p, "_no_mem_req"}, nreq, 0);
    end else begin
      chk({p, "_mem_addr"}, addr0, v.exp_addr);
      chk({p, "_mem_addr_stable"}, addr_bad, 1'b0);
      chk({p, "_mem_req_cycles"}, nreq, v.req_stall + 1);
    end
    chk({p, "_stat_hits"}, stat_hits, v.exp_hits);
    chk({p, "_stat_misses"}, stat_misses, v.exp_misses);
  endtask

  task automatic check_quiet(input string p);
    chk({p, "_miss_rdy"}, miss_rdy, 1'b1);
    chk({p, "_outputs_low"}, {vc_lookup_en, vc_write_en, mem_req_val, refill_val}, 4'b0);
    chk({p, "_counters"}, {stat_hits, stat_misses}, 32'h0);
  endtask

  vec_t vecs[6];

  initial begin
    bit bad_wr, bad_ref, bad_req;
    reset = 1'b0; miss_val = 1'b0; miss_tag = '0; miss_idx = '0;
    evict_val = 1'b0; evict_tag = '0; evict_idx = '0; evict_data = '0;
    vc_repl_way = 1'b0; mem_req_rdy = 1'b0; mem_resp_val = 1'b0; mem_resp_data = '0;
    refill_rdy = 1'b0;

    //           tag     idx  ev  ev_tag  ev_idx ev_data rw rs fs mem  src refill addr         wr way vld hits misses
    vecs[0] = mk(25'h7,  3'd1, 1, 25'h44, 3'd3, E0,     0, 0, 0, D0, 0, D0, 32'h0000_0390, 1, 0, 1, 16'd0, 16'd1);
    vecs[1] = mk(25'h10, 3'd2, 1, 25'h33, 3'd5, E1,     0, 0, 0, D0, 1, DA, 32'h0,         1, 1, 1, 16'd1, 16'd1);
    vecs[2] = mk(25'h44, 3'd3, 0, 25'h0,  3'd0, '0,     1, 0, 0, D0, 1, E0, 32'h0,         1, 0, 0, 16'd2, 16'd1);
    vecs[3] = mk(25'h44, 3'd3, 1, 25'h55, 3'd6, E3,     0, 5, 3, D3, 0, D3, 32'h0000_2230, 1, 0, 1, 16'd2, 16'd2);
    vecs[4] = mk(25'h0,  3'd7, 0, 25'h0,  3'd0, '0,     1, 1, 1, D4, 0, D4, 32'h0000_0070, 0, 0, 0, 16'd2, 16'd3);
    vecs[5] = mk(25'h33, 3'd5, 1, 25'h66, 3'd0, E5,     0, 0, 2, D0, 1, E1, 32'h0,         1, 1, 1, 16'd3, 16'd3);

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_quiet("post_reset");

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);
    chk("vc_entry1_after_swaps", {m_v[1], m_tag[1], m_idx[1]}, {1'b1, 25'h66, 3'd0});

    // reset while waiting on memory; the late response must be dropped
    @(negedge clk);
    miss_val = 1'b1; miss_tag = 25'h99; miss_idx = 3'd4;
    evict_val = 1'b1; evict_tag = 25'h77; evict_idx = 3'd1; evict_data = E5;
    @(negedge clk);
    miss_val = 1'b0;
    chk("rst_seq_lookup", vc_lookup_en, 1'b1);
    @(negedge clk);
    chk("rst_seq_memreq", mem_req_val, 1'b1);
    mem_req_rdy = 1'b1;
    @(negedge clk);
    mem_req_rdy = 1'b0;
    chk("rst_seq_memwait", {mem_req_val, refill_val, vc_write_en}, 3'b0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    mem_resp_val = 1'b1; mem_resp_data = D3;
    check_quiet("rst_seq_idle");
    bad_wr = 0; bad_ref = 0; bad_req = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      mem_resp_val = 1'b0;
      if (vc_write_en) bad_wr = 1;
      if (refill_val) bad_ref = 1;
      if (mem_req_val || vc_lookup_en) bad_req = 1;
    end
    chk("rst_seq_no_vc_write", bad_wr, 1'b0);
    chk("rst_seq_no_refill", bad_ref, 1'b0);
    chk("rst_seq_no_activity", bad_req, 1'b0);
    chk("rst_seq_miss_rdy", miss_rdy, 1'b1);

    // miss counter wrap from 0xFFFF
    @(negedge clk);
    force dut.stat_misses_q = 16'hFFFF;
    #1;
    release dut.stat_misses_q;
    @(negedge clk);
    chk("wrap_preload", stat_misses, 16'hFFFF);
    run_vec(6, mk(25'h123, 3'd0, 0, 25'h0, 3'd0, '0, 0, 0, 0, D6, 0, D6, 32'h0000_9180,
                  0, 0, 0, 16'd0, 16'd0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
